call_push_unit: RTL and testbench
=================================

Name: call_push_unit

Overview:
- Micro-sequencer inside the CPU core that performs the push half of the subroutine protocol: CALL, CALZ and interrupt entry.
- It is the inverse of the RET/RETS/RETD pop.
- Writes the return address nibbles to stack RAM below SP (PCP at SP-1, PCSH at SP-2, PCSL at SP-3), updates SP by -3, then loads the new PC.
- Sits between the decoder and the RAM/register-file write ports. Advances only on clk_en cycles.

Parameters:
- PC_WIDTH, 13, full PC width: bank bit, PCP[11:8], PCS[7:0].
- INT_PAGE, 4'h1, PCP loaded on interrupt entry.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  CPU step enable; all state advances only when high
- start  in  1  one-cycle request (sampled when clk_en=1 and idle)
- kind  in  2  0=CALL, 1=CALZ, 2=INT, 3=reserved (treated as CALL)
- pc_in  in  13  address of the current instruction
- npp_in  in  5  NBP/NPP latch: bank bit + page
- target_in  in  8  immediate s (CALL/CALZ) or interrupt vector
- sp_in  in  8  current SP
- ram_addr  out  12  stack write address, {4'h0, sp}
- ram_wdata  out  4  nibble to write
- ram_we  out  1  write strobe
- sp_out  out  8  new SP value
- sp_we  out  1  SP write strobe
- pc_out  out  13  new PC
- pc_we  out  1  PC load strobe
- clear_i  out  1  one-cycle strobe to clear the I flag (INT only)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE. All outputs are 0: ram_addr, ram_wdata, ram_we, sp_out, sp_we, pc_out, pc_we, clear_i, busy, done. Reset mid-sequence aborts immediately; no further writes occur.
- On start: latch ret = pc_in+1 (13-bit; the bank bit is carried from pc_in and never altered by the increment), plus kind, target_in and sp_in into sp_r.
- States, one clk_en cycle each:
  - IDLE
  - W_PCP: addr sp_r-1, data ret[11:8]
  - W_PCSH: addr sp_r-2, data ret[7:4]
  - W_PCSL: addr sp_r-3, data ret[3:0]
  - COMMIT
  - back to IDLE.
- COMMIT cycle:
  - sp_we=1, sp_out=sp_r-3.
  - pc_we=1 with pc_out by kind:
    - CALL: {npp_in, target}
    - CALZ: {pc bank, 4'h0, target}
    - INT: {pc bank, INT_PAGE, target}
  - clear_i=1 when kind=INT.
  - done=1.
- Latency: start to done is 4 enabled cycles. ram_we is high in exactly 3 enabled cycles.
- SP arithmetic is 8-bit modulo: sp_in=8'h01 gives writes at 0x000, 0x0FF, 0x0FE and SP=8'hFE.
- clk_en=0 holds state and forces all strobes to 0; addr/data hold their values.
- start while busy is ignored.
- Simultaneous start and reset: reset wins.
- npp_in is sampled at COMMIT, not at start; the decoder holds it stable.
- Round trip: RET on the resulting SP must restore PC=ret and SP=sp_in.

Optional Feature:
- STACK_GUARD_EN
- Defined: adds output stack_wrap (1 bit, sticky). It is set when any push address wraps past 0x00 (sp_in < 3 at start) and cleared only by reset. Sequence behaviour is unchanged.
- Undefined: no port, no logic.

Decomposition:
- Shared core package (existing cpu package) holds:
  - push_kind_t enum {PUSH_CALL, PUSH_CALZ, PUSH_INT}
  - push_state_t enum
  - constants STACK_PAGE=4'h0 and PUSH_CYCLES=4
- No sub-module is needed; one FSM module.

Test Plan:
- CALL with pc_in=13'h0240, npp_in=5'h07, target=8'h4D, sp_in=8'h47 -> RAM[0x046]=2, [0x045]=4, [0x044]=1; SP=8'h44; PC=13'h074D; done after 4 enabled cycles.
- CALZ with pc_in=13'h1FFF, target=8'h10, sp_in=8'h20 -> ret wraps within bank to 13'h1000: writes 0,0,0 at 0x01F..0x01D; PC=13'h1010; SP=8'h1D.
- INT with pc_in=13'h0312, vector 8'h0C, sp_in=8'h80 -> writes 3,1,3; PC=13'h010C; clear_i pulses once at COMMIT.
- sp_in=8'h01 -> writes at 0x000, 0x0FF, 0x0FE; SP=8'hFE; with STACK_GUARD_EN, stack_wrap=1.
- clk_en toggling 1/0 -> sequence stretches to 8 clk cycles with identical writes; start during busy is ignored.
- Reset asserted after the W_PCSH write -> no PCSL write and no SP/PC strobes; all outputs return to 0.

Source files
------------

// File: rtl/call_push_unit_pkg.sv
// Shared core definitions for the subroutine push sequencer (CALL, CALZ and
// interrupt entry): push kinds, FSM states and stack constants.
package call_push_unit_pkg;

  typedef enum logic [1:0] {
    PUSH_CALL = 2'd0,
    PUSH_CALZ = 2'd1,
    PUSH_INT  = 2'd2
  } push_kind_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_PCP  = 3'd1,
    S_W_PCSH = 3'd2,
    S_W_PCSL = 3'd3,
    S_COMMIT = 3'd4
  } push_state_t;

  localparam logic [3:0] STACK_PAGE  = 4'h0;
  localparam int         PUSH_CYCLES = 4;

  // The reserved kind encoding 3 behaves exactly like a plain CALL.
  function automatic push_kind_t decode_kind(input logic [1:0] raw);
    case (raw)
      2'd1:    return PUSH_CALZ;
      2'd2:    return PUSH_INT;
      default: return PUSH_CALL;
    endcase
  endfunction

endpackage

// File: rtl/call_push_unit_if.sv
// Request/response bundle between the decoder, the push sequencer and the
// RAM / register-file write ports. The stack_wrap signal exists only when
// STACK_GUARD_EN is defined.
interface call_push_if #(
  parameter int PC_WIDTH = 13
);

  logic                start;
  logic [1:0]          kind;
  logic [PC_WIDTH-1:0] pc_in;
  logic [4:0]          npp_in;
  logic [7:0]          target_in;
  logic [7:0]          sp_in;

  logic [11:0]         ram_addr;
  logic [3:0]          ram_wdata;
  logic                ram_we;
  logic [7:0]          sp_out;
  logic                sp_we;
  logic [PC_WIDTH-1:0] pc_out;
  logic                pc_we;
  logic                clear_i;
  logic                busy;
  logic                done;
`ifdef STACK_GUARD_EN
  logic                stack_wrap;
`endif

  modport master (
    output start, kind, pc_in, npp_in, target_in, sp_in,
    input  ram_addr, ram_wdata, ram_we, sp_out, sp_we,
    input  pc_out, pc_we, clear_i, busy, done
`ifdef STACK_GUARD_EN
    , input stack_wrap
`endif
  );

  modport slave (
    input  start, kind, pc_in, npp_in, target_in, sp_in,
    output ram_addr, ram_wdata, ram_we, sp_out, sp_we,
    output pc_out, pc_we, clear_i, busy, done
`ifdef STACK_GUARD_EN
    , output stack_wrap
`endif
  );

endinterface

// File: rtl/call_push_unit.sv
// Push half of the subroutine protocol: writes the return address nibbles
// below SP (PCP, PCSH, PCSL), drops SP by 3 and loads the new PC. Advances
// only on clk_en cycles. Define STACK_GUARD_EN to add the sticky stack_wrap
// output flagging pushes that wrap below address 0x00.
module call_push_unit
  import call_push_unit_pkg::*;
#(
  parameter int         PC_WIDTH = 13,
  parameter logic [3:0] INT_PAGE = 4'h1
) (
  input logic        clk,
  input logic        reset,
  input logic        clk_en,
  call_push_if.slave bus
);

  push_state_t         state;
  push_kind_t          kind_r;
  logic [PC_WIDTH-1:0] ret_r;
  logic [7:0]          target_r;
  logic [7:0]          sp_r;

  logic [11:0]         ram_addr_r;
  logic [3:0]          ram_wdata_r;
  logic                ram_we_r;
  logic [7:0]          sp_out_r;
  logic                sp_we_r;
  logic [PC_WIDTH-1:0] pc_out_r;
  logic                pc_we_r;
  logic                clear_i_r;
  logic                busy_r;
  logic                done_r;

  logic [PC_WIDTH-1:0] ret_next;
  logic [PC_WIDTH-1:0] pc_commit;

  // Return address increments inside the bank; the bank bit never changes.
  assign ret_next = {bus.pc_in[PC_WIDTH-1],
                     bus.pc_in[PC_WIDTH-2:0] + (PC_WIDTH-1)'(1)};

  // New PC for the commit step; npp_in is read live because the decoder holds it.
  always_comb begin
    pc_commit = '0;
    case (kind_r)
      PUSH_CALZ: pc_commit = {ret_r[PC_WIDTH-1], 4'h0, target_r};
      PUSH_INT:  pc_commit = {ret_r[PC_WIDTH-1], INT_PAGE, target_r};
      default:   pc_commit = {bus.npp_in, target_r};
    endcase
  end

  // Push sequencer: one enabled cycle per step, strobes registered per state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      kind_r      <= PUSH_CALL;
      ret_r       <= '0;
      target_r    <= '0;
      sp_r        <= '0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_we_r    <= 1'b0;
      sp_out_r    <= '0;
      sp_we_r     <= 1'b0;
      pc_out_r    <= '0;
      pc_we_r     <= 1'b0;
      clear_i_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (clk_en) begin
      ram_we_r  <= 1'b0;
      sp_we_r   <= 1'b0;
      pc_we_r   <= 1'b0;
      clear_i_r <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            kind_r      <= decode_kind(bus.kind);
            ret_r       <= ret_next;
            target_r    <= bus.target_in;
            sp_r        <= bus.sp_in;
            ram_addr_r  <= {STACK_PAGE, bus.sp_in - 8'd1};
            ram_wdata_r <= ret_next[11:8];
            ram_we_r    <= 1'b1;
            busy_r      <= 1'b1;
            state       <= S_W_PCP;
          end
        end
        S_W_PCP: begin
          ram_addr_r  <= {STACK_PAGE, sp_r - 8'd2};
          ram_wdata_r <= ret_r[7:4];
          ram_we_r    <= 1'b1;
          state       <= S_W_PCSH;
        end
        S_W_PCSH: begin
          ram_addr_r  <= {STACK_PAGE, sp_r - 8'd3};
          ram_wdata_r <= ret_r[3:0];
          ram_we_r    <= 1'b1;
          state       <= S_W_PCSL;
        end
        S_W_PCSL: begin
          sp_out_r  <= sp_r - 8'd3;
          sp_we_r   <= 1'b1;
          pc_out_r  <= pc_commit;
          pc_we_r   <= 1'b1;
          clear_i_r <= (kind_r == PUSH_INT);
          done_r    <= 1'b1;
          state     <= S_COMMIT;
        end
        S_COMMIT: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef STACK_GUARD_EN
  logic stack_wrap_r;

  // Sticky flag for any accepted push whose frame crosses below address 0x00.
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_wrap_r <= 1'b0;
    end else if (clk_en && state == S_IDLE && bus.start && bus.sp_in < 8'd3) begin
      stack_wrap_r <= 1'b1;
    end
  end

  assign bus.stack_wrap = stack_wrap_r;
`else
  // Default build: no wrap tracking and no stack_wrap signal on the bus.
`endif

  // Strobes are suppressed on stalled cycles; address and data simply hold.
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.ram_we    = ram_we_r & clk_en;
  assign bus.sp_out    = sp_out_r;
  assign bus.sp_we     = sp_we_r & clk_en;
  assign bus.pc_out    = pc_out_r;
  assign bus.pc_we     = pc_we_r & clk_en;
  assign bus.clear_i   = clear_i_r & clk_en;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r & clk_en;

endmodule

// File: tb/tb_call_push_unit.sv
// Self-checking bench for call_push_unit: directed vector table, random
// transactions against a behavioural push model, and hand-written reset
// sequences. Honours STACK_GUARD_EN for the stack_wrap flag.
module tb_call_push_unit;
  import call_push_unit_pkg::*;

  typedef struct {
    logic [1:0]       kind;
    logic [12:0]      pc;
    logic [4:0]       npp;
    logic [7:0]       target;
    logic [7:0]       sp;
    logic [2:0][11:0] exp_addr;
    logic [2:0][3:0]  exp_data;
    logic [12:0]      exp_pc;
    logic [7:0]       exp_sp;
    logic             exp_clear;
  } vec_t;

  logic clk;
  logic reset;
  logic clk_en;

  int pass_count = 0;
  int check_count = 0;
  bit wrap_seen = 1'b0;

  call_push_if #(.PC_WIDTH(13)) bus();

  call_push_unit #(.PC_WIDTH(13), .INT_PAGE(4'h1)) dut (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .bus   (bus)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic vec_t mk_vec(input logic [1:0] kind, input logic [12:0] pc,
                                  input logic [4:0] npp, input logic [7:0] target,
                                  input logic [7:0] sp,
                                  input logic [11:0] a0, input logic [11:0] a1,
                                  input logic [11:0] a2,
                                  input logic [3:0] d0, input logic [3:0] d1,
                                  input logic [3:0] d2,
                                  input logic [12:0] epc, input logic [7:0] esp,
                                  input logic eclr);
    vec_t v;
    v.kind = kind; v.pc = pc; v.npp = npp; v.target = target; v.sp = sp;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2;
    v.exp_data[0] = d0; v.exp_data[1] = d1; v.exp_data[2] = d2;
    v.exp_pc = epc; v.exp_sp = esp; v.exp_clear = eclr;
    return v;
  endfunction

  // Behavioural model: return address in its bank, three nibbles below SP, new PC by kind.
  function automatic vec_t model(input logic [1:0] kind, input logic [12:0] pc,
                                 input logic [4:0] npp, input logic [7:0] target,
                                 input logic [7:0] sp);
    vec_t v;
    int bank, ret, new_pc;
    v.kind = kind; v.pc = pc; v.npp = npp; v.target = target; v.sp = sp;
    bank = (int'(pc) / 4096) * 4096;
    ret  = bank + ((int'(pc) % 4096) + 1) % 4096;
    for (int i = 0; i < 3; i++) begin
      v.exp_addr[i] = 12'((int'(sp) - (i + 1) + 256) % 256);
      v.exp_data[i] = 4'((ret >> (8 - 4 * i)) % 16);
    end
    v.exp_sp = 8'((int'(sp) + 253) % 256);
    case (kind)
      2'd1:    new_pc = bank + int'(target);
      2'd2:    new_pc = bank + 256 + int'(target);
      default: new_pc = int'(npp) * 256 + int'(target);
    endcase
    v.exp_pc = 13'(new_pc);
    v.exp_clear = (kind == 2'd2);
    return v;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'h0);
    checkOutput({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'h0);
    checkOutput({tag, "_ram_we"}, 32'(bus.ram_we), 32'h0);
    checkOutput({tag, "_sp_out"}, 32'(bus.sp_out), 32'h0);
    checkOutput({tag, "_sp_we"}, 32'(bus.sp_we), 32'h0);
    checkOutput({tag, "_pc_out"}, 32'(bus.pc_out), 32'h0);
    checkOutput({tag, "_pc_we"}, 32'(bus.pc_we), 32'h0);
    checkOutput({tag, "_clear_i"}, 32'(bus.clear_i), 32'h0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'h0);
`ifdef STACK_GUARD_EN
    checkOutput({tag, "_stack_wrap"}, 32'(bus.stack_wrap), 32'h0);
`endif
  endtask

  // One push transaction; toggle=1 stalls every other cycle and injects a start while busy.
  task automatic applyStimulus(input vec_t v, input bit toggle, input string tag);
    int  en_cycles = 0, clk_cycles = 0, writes = 0, spw = 0, pcw = 0, clr = 0;
    int  bad_strobe = 0, extra = 0;
    bit  got_done = 1'b0;
    logic [12:0] pc_seen = '0;
    logic [7:0]  sp_seen = '0;
    @(negedge clk);
    bus.kind = v.kind; bus.pc_in = v.pc; bus.npp_in = v.npp;
    bus.target_in = v.target; bus.sp_in = v.sp;
    bus.start = 1'b1; clk_en = 1'b1;
    if (v.sp < 8'd3) wrap_seen = 1'b1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      clk_cycles++;
      clk_en = toggle ? (c % 2 == 1) : 1'b1;
      bus.start = toggle && clk_en && (en_cycles == 1);
      if (bus.start) begin
        bus.kind = 2'd2;
        bus.sp_in = v.sp ^ 8'hFF;
      end
      #1;
      if (!clk_en) begin
        if (bus.ram_we || bus.sp_we || bus.pc_we || bus.clear_i || bus.done) bad_strobe++;
      end else begin
        en_cycles++;
        if (bus.ram_we) begin
          if (writes < 3) begin
            checkOutput($sformatf("%s_wr%0d_addr", tag, writes), 32'(bus.ram_addr),
                        32'(v.exp_addr[writes]));
            checkOutput($sformatf("%s_wr%0d_data", tag, writes), 32'(bus.ram_wdata),
                        32'(v.exp_data[writes]));
          end
          writes++;
        end
        if (bus.sp_we) begin spw++; sp_seen = bus.sp_out; end
        if (bus.pc_we) begin pcw++; pc_seen = bus.pc_out; end
        if (bus.clear_i) clr++;
        if (bus.done) begin
          got_done = 1'b1;
          checkOutput({tag, "_latency"}, 32'(en_cycles), 32'(PUSH_CYCLES));
          checkOutput({tag, "_clk_cycles"}, 32'(clk_cycles), toggle ? 32'd8 : 32'd4);
          checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'h1);
        end
      end
    end
    bus.start = 1'b0;
    if (!got_done) checkOutput({tag, "_done_seen"}, 32'h0, 32'h1);
    checkOutput({tag, "_write_count"}, 32'(writes), 32'd3);
    checkOutput({tag, "_sp_we_count"}, 32'(spw), 32'd1);
    checkOutput({tag, "_pc_we_count"}, 32'(pcw), 32'd1);
    checkOutput({tag, "_sp_out"}, 32'(sp_seen), 32'(v.exp_sp));
    checkOutput({tag, "_pc_out"}, 32'(pc_seen), 32'(v.exp_pc));
    checkOutput({tag, "_clear_i_count"}, 32'(clr), 32'(v.exp_clear));
    checkOutput({tag, "_stalled_strobes"}, 32'(bad_strobe), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clk_en = 1'b1;
      #1;
      if (bus.ram_we || bus.busy || bus.sp_we || bus.pc_we) extra++;
    end
    checkOutput({tag, "_idle_after"}, 32'(extra), 32'd0);
`ifdef STACK_GUARD_EN
    checkOutput({tag, "_stack_wrap"}, 32'(bus.stack_wrap), 32'(wrap_seen));
`endif
  endtask

  // Reset arrives during the PCSH write cycle: the push must stop right there.
  task automatic resetMidSequence();
    int writes = 0, late = 0;
    @(negedge clk);
    bus.kind = 2'd0; bus.pc_in = 13'h0240; bus.npp_in = 5'h07;
    bus.target_in = 8'h4D; bus.sp_in = 8'h47; bus.start = 1'b1; clk_en = 1'b1;
    for (int c = 0; c < 10 && writes < 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.ram_we) writes++;
      if (writes == 2) reset = 1'b1;
    end
    checkOutput("rstmid_writes_before", 32'(writes), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    wrap_seen = 1'b0;
    #1;
    checkAllZero("rstmid");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (bus.ram_we || bus.sp_we || bus.pc_we || bus.done || bus.busy) late++;
    end
    checkOutput("rstmid_no_late_strobes", 32'(late), 32'd0);
  endtask

  // Start and reset in the same cycle: reset wins and nothing is launched.
  task automatic resetWithStart();
    int late = 0;
    @(negedge clk);
    bus.kind = 2'd2; bus.sp_in = 8'h30; bus.start = 1'b1; reset = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; reset = 1'b0;
    wrap_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.ram_we || bus.busy || bus.done) late++;
      @(negedge clk);
    end
    checkOutput("rst_start_ignored", 32'(late), 32'd0);
  endtask

  vec_t dir_tbl[6];

  initial begin
    vec_t rv;
    dir_tbl[0] = mk_vec(2'd0, 13'h0240, 5'h07, 8'h4D, 8'h47, 12'h046, 12'h045, 12'h044,
                        4'h2, 4'h4, 4'h1, 13'h074D, 8'h44, 1'b0);
    dir_tbl[1] = mk_vec(2'd1, 13'h1FFF, 5'h1F, 8'h10, 8'h20, 12'h01F, 12'h01E, 12'h01D,
                        4'h0, 4'h0, 4'h0, 13'h1010, 8'h1D, 1'b0);
    dir_tbl[2] = mk_vec(2'd2, 13'h0312, 5'h05, 8'h0C, 8'h80, 12'h07F, 12'h07E, 12'h07D,
                        4'h3, 4'h1, 4'h3, 13'h010C, 8'h7D, 1'b1);
    dir_tbl[3] = mk_vec(2'd0, 13'h0ABC, 5'h12, 8'h34, 8'h01, 12'h000, 12'h0FF, 12'h0FE,
                        4'hA, 4'hB, 4'hD, 13'h1234, 8'hFE, 1'b0);
    dir_tbl[4] = mk_vec(2'd3, 13'h1005, 5'h03, 8'h99, 8'h02, 12'h001, 12'h000, 12'h0FF,
                        4'h0, 4'h0, 4'h6, 13'h0399, 8'hFF, 1'b0);
    dir_tbl[5] = mk_vec(2'd2, 13'h1234, 5'h00, 8'hF0, 8'h00, 12'h0FF, 12'h0FE, 12'h0FD,
                        4'h2, 4'h3, 4'h5, 13'h11F0, 8'hFD, 1'b1);

    reset = 1'b1; clk_en = 1'b0; bus.start = 1'b0; bus.kind = 2'd0;
    bus.pc_in = '0; bus.npp_in = '0; bus.target_in = '0; bus.sp_in = '0;
    repeat (2) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++)
      applyStimulus(dir_tbl[i], 1'b0, $sformatf("dir%0d", i));
    applyStimulus(dir_tbl[0], 1'b1, "dir0_stall");

    $display("[TB] reset corner cases");
    resetMidSequence();
    resetWithStart();

    $display("[TB] random transactions");
    for (int i = 0; i < 40; i++) begin
      logic [7:0] sp;
      sp = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      rv = model(2'($urandom_range(0, 3)), 13'($urandom), 5'($urandom),
                 8'($urandom), sp);
      applyStimulus(rv, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
